led_frame_buffer: RTL and testbench

Double-buffered 16x16x2 frame store with scan-tick generation, sitting directly upstream of the LED matrix display driver. Game logic writes whole rows into a hidden back buffer, then requests a swap. The block exchanges front and back buffers only at a scan-frame boundary, so the display never shows a half-updated frame. It also generates the driver's row-advance strobe and tracks the driver's scan position to find those boundaries.

---
 rtl/led_frame_buffer_if.sv | 25 ++
 rtl/led_frame_buffer.sv | 124 ++++++++++++
 tb/tb_led_frame_buffer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/led_frame_buffer_if.sv
// Row-write / swap request bus from game logic, plus front-buffer pixel and
// row-advance strobe outputs toward the LED matrix driver.
interface led_frame_buffer_if;
    logic              WrEn;
    logic [3:0]        WrRow;
    logic [15:0]       WrRed;
    logic [15:0]       WrGrn;
    logic              SwapReq;
    logic              ClearReq;
    logic              Ready;
    logic              SwapDone;
    logic [15:0][15:0] RedPixels;
    logic [15:0][15:0] GrnPixels;
    logic              EnableCount;

    modport master (
        output WrEn, WrRow, WrRed, WrGrn, SwapReq, ClearReq,
        input  Ready, SwapDone, RedPixels, GrnPixels, EnableCount
    );

    modport slave (
        input  WrEn, WrRow, WrRed, WrGrn, SwapReq, ClearReq,
        output Ready, SwapDone, RedPixels, GrnPixels, EnableCount
    );
endinterface

// File: rtl/led_frame_buffer.sv
// Double-buffered 16x16 red/green frame store; swaps front/back only on the
// last scan tick of a display frame so the driver never shows a torn frame.
module led_frame_buffer #(
    parameter int TICKDIV = 50000,
    parameter int FREQDIV = 0
) (
    input logic               CLK,
    input logic               RST,
    led_frame_buffer_if.slave bus
);

    localparam int TW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
    localparam int SW = FREQDIV + 4;

    typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     tick_cnt;
    logic [SW-1:0]     scan_cnt;
    logic [3:0]        clr_row;
    logic              front_sel;
    logic              swap_done;
    logic              enable_count;
    logic              frame_end;
    logic              wr_go, clr_go, swap_go;
    logic [15:0][15:0] red_a, grn_a, red_b, grn_b;

    assign enable_count = (tick_cnt == TW'(TICKDIV - 1));
    assign frame_end    = enable_count && (scan_cnt == '1);

    // Prescaler and scan-position tracker; ScanCnt mirrors the driver's row/phase count.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            tick_cnt <= '0;
            scan_cnt <= '0;
        end else begin
            tick_cnt <= enable_count ? '0 : tick_cnt + 1'b1;
            if (enable_count)
                scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_go     = 1'b0;
        clr_go    = 1'b0;
        swap_go   = 1'b0;
        case (state)
            IDLE: begin
                wr_go = bus.WrEn;
                if (bus.ClearReq)
                    state_nxt = CLEAR;
                else if (bus.SwapReq)
                    state_nxt = SWAP_WAIT;
            end
            CLEAR: begin
                clr_go = 1'b1;
                if (clr_row == 4'd15)
                    state_nxt = IDLE;
            end
            SWAP_WAIT: begin
                // Entry edge never counts: frame_end is only examined once we are here.
                if (frame_end) begin
                    swap_go   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            red_a     <= '0;
            grn_a     <= '0;
            red_b     <= '0;
            grn_b     <= '0;
            front_sel <= 1'b0;
            clr_row   <= '0;
            swap_done <= 1'b0;
        end else begin
            // Back buffer is A when B is in front, and vice versa.
            if (wr_go) begin
                if (front_sel) begin
                    red_a[bus.WrRow] <= bus.WrRed;
                    grn_a[bus.WrRow] <= bus.WrGrn;
                end else begin
                    red_b[bus.WrRow] <= bus.WrRed;
                    grn_b[bus.WrRow] <= bus.WrGrn;
                end
            end
            if (clr_go) begin
                if (front_sel) begin
                    red_a[clr_row] <= '0;
                    grn_a[clr_row] <= '0;
                end else begin
                    red_b[clr_row] <= '0;
                    grn_b[clr_row] <= '0;
                end
            end
            if (state == IDLE)
                clr_row <= '0;
            else if (clr_go)
                clr_row <= clr_row + 1'b1;
            if (swap_go)
                front_sel <= ~front_sel;
            swap_done <= swap_go;
        end
    end

    assign bus.Ready       = (state == IDLE);
    assign bus.SwapDone    = swap_done;
    assign bus.EnableCount = enable_count;
    assign bus.RedPixels   = front_sel ? red_b : red_a;
    assign bus.GrnPixels   = front_sel ? grn_b : grn_a;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench for led_frame_buffer with TICKDIV=4, FREQDIV=0 (64-cycle frame).
module tb_led_frame_buffer;

    logic CLK;
    logic RST;
    int   n_chk;
    int   n_fail;
    int   cyc;

    led_frame_buffer_if bus();

    led_frame_buffer #(.TICKDIV(4), .FREQDIV(0)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // All driving and sampling happens 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        bus.WrEn = 0; bus.WrRow = 0; bus.WrRed = 0; bus.WrGrn = 0;
        bus.SwapReq = 0; bus.ClearReq = 0;
        RST = 1'b0;
        step();
        step();
        RST = 1'b1;
        cyc = 0;
    endtask

    task automatic wr(input logic [3:0] row, input logic [15:0] r, input logic [15:0] g);
        bus.WrEn = 1; bus.WrRow = row; bus.WrRed = r; bus.WrGrn = g;
        step();
        bus.WrEn = 0;
    endtask

    task automatic wait_swap(output bit ok);
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            step();
            if (bus.SwapDone) ok = 1;
        end
    endtask

    task automatic swap_now();
        bit ok;
        bus.SwapReq = 1;
        step();
        bus.SwapReq = 0;
        wait_swap(ok);
        chk("swap_timeout", ok, 1);
    endtask

    initial begin
        int cnt, sd;
        n_chk = 0; n_fail = 0; cyc = 0;
        RST = 1'b0;
        do_reset();

        // 1. reset state and prescaler phase
        chk("rst_red", bus.RedPixels, 0);
        chk("rst_grn", bus.GrnPixels, 0);
        chk("rst_ready", bus.Ready, 1);
        chk("rst_swapdone", bus.SwapDone, 0);
        for (int k = 0; k < 12; k++) begin
            chk("en_phase", bus.EnableCount, (k % 4 == 3));
            step();
        end

        // 2/3. write, swap at frame boundary, rejected write while waiting
        wr(4'd5, 16'h00FF, 16'hF000);
        chk("wr_hidden", bus.RedPixels[5], 0);
        bus.SwapReq = 1;
        step();
        bus.SwapReq = 0;
        chk("sw_ready_lo", bus.Ready, 0);
        wr(4'd2, 16'hFFFF, 16'hFFFF);
        chk("rej_ready_lo", bus.Ready, 0);
        while (cyc < 63) step();
        chk("pre_swap_red", bus.RedPixels[5], 0);
        chk("pre_swap_done", bus.SwapDone, 0);
        step();
        chk("swap_red5", bus.RedPixels[5], 16'h00FF);
        chk("swap_grn5", bus.GrnPixels[5], 16'hF000);
        chk("swap_done", bus.SwapDone, 1);
        chk("swap_ready", bus.Ready, 1);
        step();
        chk("swap_done_1cyc", bus.SwapDone, 0);
        chk("rej_red2", bus.RedPixels[2], 0);
        chk("rej_grn2", bus.GrnPixels[2], 0);

        // 4. fill back buffer, clear it, swap in zeros
        for (int r = 0; r < 16; r++) wr(4'(r), 16'hFFFF, 16'hFFFF);
        chk("fill_hidden", bus.RedPixels[0], 0);
        bus.ClearReq = 1;
        step();
        bus.ClearReq = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.Ready) cnt++;
            step();
        end
        chk("clr_len", cnt, 16);
        chk("clr_front_kept", bus.RedPixels[5], 16'h00FF);
        swap_now();
        chk("clr_red", bus.RedPixels, 0);
        chk("clr_grn", bus.GrnPixels, 0);

        // 5. clear + swap + write together: clear wins, no swap
        bus.WrEn = 1; bus.WrRow = 4'd7; bus.WrRed = 16'hFFFF; bus.WrGrn = 16'hFFFF;
        bus.ClearReq = 1; bus.SwapReq = 1;
        step();
        bus.WrEn = 0; bus.ClearReq = 0; bus.SwapReq = 0;
        chk("sim_ready_lo", bus.Ready, 0);
        cnt = 0; sd = 0;
        for (int i = 0; i < 90; i++) begin
            if (!bus.Ready) cnt++;
            if (bus.SwapDone) sd++;
            step();
        end
        chk("sim_clr_len", cnt, 16);
        chk("sim_no_swap", sd, 0);
        swap_now();
        chk("sim_red7", bus.RedPixels[7], 0);
        chk("sim_grn7", bus.GrnPixels[7], 0);
        chk("sim_red5", bus.RedPixels[5], 0);

        // 6. reset in SWAP_WAIT, then a request on the FrameEnd cycle
        wr(4'd3, 16'h1234, 16'h5678);
        swap_now();
        chk("pre_rst_red3", bus.RedPixels[3], 16'h1234);
        chk("pre_rst_grn3", bus.GrnPixels[3], 16'h5678);
        wr(4'd4, 16'hAAAA, 16'h5555);
        swap_now();
        chk("pre_rst_red4", bus.RedPixels[4], 16'hAAAA);
        bus.SwapReq = 1;
        step();
        bus.SwapReq = 0;
        for (int i = 0; i < 5; i++) step();
        do_reset();
        chk("mid_rst_red", bus.RedPixels, 0);
        chk("mid_rst_grn", bus.GrnPixels, 0);
        chk("mid_rst_ready", bus.Ready, 1);
        chk("mid_rst_front", dut.front_sel, 0);
        sd = 0;
        for (int i = 0; i < 70; i++) begin
            if (bus.SwapDone) sd++;
            step();
        end
        chk("mid_rst_no_swap", sd, 0);
        wr(4'd1, 16'h8001, 16'h4002);
        while (cyc < 127) step();
        bus.SwapReq = 1;
        step();
        bus.SwapReq = 0;
        chk("fe_req_no_swap", bus.SwapDone, 0);
        chk("fe_req_ready", bus.Ready, 0);
        chk("fe_req_red1", bus.RedPixels[1], 0);
        while (cyc < 191) step();
        chk("fe_wait_done", bus.SwapDone, 0);
        chk("fe_wait_red1", bus.RedPixels[1], 0);
        step();
        chk("fe_swap_done", bus.SwapDone, 1);
        chk("fe_swap_red1", bus.RedPixels[1], 16'h8001);
        chk("fe_swap_grn1", bus.GrnPixels[1], 16'h4002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
